// File: rtl/ula_multiciclo.sv
// Execution-stage ALU: single-cycle logic/arith/compare/branch ops plus
// iterative signed mult (shift-add) and div (restoring) behind start/busy/done.
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       controle,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             branch_ok,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg;
    // opx: multiplicand / divisor; opy: multiplier / dividend->quotient
    logic [WIDTH-1:0] opx;
    logic [WIDTH-1:0] opy;
    logic [WIDTH-1:0] acc;

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] alu_r;
    logic             alu_br;
    logic             is_mul_op;
    logic             is_div_op;
    logic             div0;
    logic             multi;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] sub_r;
    logic [WIDTH-1:0] mag;

    assign sa        = a;
    assign sb        = b;
    assign diff      = a - b;
    assign mag_a     = a[WIDTH-1] ? -a : a;
    assign mag_b     = b[WIDTH-1] ? -b : b;
    assign is_mul_op = (controle == 5'd2);
    assign is_div_op = (controle == 5'd3);
    assign div0      = is_div_op && (b == '0);
    assign multi     = (is_mul_op || is_div_op) && !div0;

    assign shifted = {acc, opy[WIDTH-1]};
    assign ge      = shifted >= {1'b0, opx};
    assign sub_r   = WIDTH'(shifted - {1'b0, opx});
    assign mag     = is_div ? opy : acc;

    always_comb begin
        alu_r  = '0;
        alu_br = 1'b0;
        case (controle)
            5'd0:    alu_r = a + b;
            5'd1:    alu_r = diff;
            5'd3:    alu_r = '1;
            5'd4:    alu_r = a & b;
            5'd5:    alu_r = a | b;
            5'd6:    alu_r = ~(a & b);
            5'd7:    alu_r = ~(a | b);
            5'd8: begin
                alu_r  = diff;
                alu_br = (a == b);
            end
            5'd9: begin
                alu_r  = diff;
                alu_br = (a != b);
            end
            5'd11:   alu_r = (sa < sb) ? WIDTH'(1) : '0;
            5'd12:   alu_r = (sa <= sb) ? WIDTH'(1) : '0;
            5'd13: begin
                alu_r  = diff;
                alu_br = (sa < sb);
            end
            5'd31:   alu_r = b;
            default: alu_r = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            neg       <= 1'b0;
            opx       <= '0;
            opy       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            branch_ok <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && multi) begin
                        state  <= S_CALC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        acc    <= '0;
                        opx    <= mag_b;
                        opy    <= mag_a;
                        is_div <= is_div_op;
                        neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                    end else if (start) begin
                        result    <= alu_r;
                        branch_ok <= alu_br;
                        div_zero  <= div0;
                        done      <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc <= ge ? sub_r : shifted[WIDTH-1:0];
                        opy <= {opy[WIDTH-2:0], ge};
                    end else begin
                        if (opy[0])
                            acc <= acc + opx;
                        opx <= opx << 1;
                        opy <= opy >> 1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    result    <= neg ? -mag : mag;
                    branch_ok <= 1'b0;
                    div_zero  <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
